// File: rtl/bpu_btb_sat.sv
// Branch target buffer with 2-bit saturating direction counters and tree pseudo-LRU replacement.
// Predicts in IC, carries each prediction down to EX, and trains from the branch resolved in EX.
module bpu_btb_sat #(
    parameter int         ENTRIES  = 8,
    parameter int         PC_W     = 32,
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      stall,
    input  logic            flush,
    input  logic            br_redirect,
    input  logic [PC_W-1:0] if_pc,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            bp_e,
    output logic [PC_W-1:0] bp_target,
    output logic            ex_bp_e,
    output logic [PC_W-1:0] ex_bp_target,
    output logic            ex_bp_hit
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int LRU_N = ENTRIES - 1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [PC_W-1:0]    tag_q [ENTRIES];
    logic [PC_W-1:0]    tag_d [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];
    logic [PC_W-1:0]    tgt_d [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic [1:0]         ctr_d [ENTRIES];
    logic [LRU_N-1:0]   lru_q, lru_d;

    logic [PC_W-1:0] ic_pc_q, ic_pc_d;
    logic [PC_W-1:0] id_pc_q, id_pc_d, id_tgt_q, id_tgt_d;
    logic            id_bp_e_q, id_bp_e_d, id_hit_q, id_hit_d;
    logic [PC_W-1:0] ex_pc_q, ex_pc_d, ex_tgt_q, ex_tgt_d;
    logic            ex_bp_e_q, ex_bp_e_d, ex_hit_q, ex_hit_d;

    logic            stall_unused;
    assign stall_unused = stall[0] ^ stall[5];

    function automatic logic [IDX_W-1:0] first_set(input logic [ENTRIES-1:0] v);
        first_set = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) first_set = IDX_W'(i);
        end
    endfunction

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right); bit 0 means go left.
    function automatic logic [LRU_N-1:0] plru_touch(input logic [LRU_N-1:0] t,
                                                    input logic [IDX_W-1:0] w);
        int n;
        n = 0;
        plru_touch = t;
        for (int d = 0; d < IDX_W; d++) begin
            plru_touch[n] = ~w[IDX_W-1-d];
            n = 2 * n + (w[IDX_W-1-d] ? 2 : 1);
        end
    endfunction

    function automatic logic [IDX_W-1:0] plru_victim(input logic [LRU_N-1:0] t);
        int n;
        n = 0;
        plru_victim = '0;
        for (int d = 0; d < IDX_W; d++) begin
            plru_victim[IDX_W-1-d] = t[n];
            n = 2 * n + (t[n] ? 2 : 1);
        end
    endfunction

    logic [ENTRIES-1:0] hit_way, upd_match;
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_cam
            // PC 0 marks a bubble and must never hit
            assign hit_way[gi]   = valid_q[gi] && (tag_q[gi] == ic_pc_q) && (ic_pc_q != '0);
            assign upd_match[gi] = valid_q[gi] && (tag_q[gi] == ex_pc_q);
        end
    endgenerate

    logic [IDX_W-1:0] hit_idx, upd_idx, alloc_idx;
    logic             lookup_hit, upd_en, upd_hit;

    assign lookup_hit = |hit_way;
    assign hit_idx    = first_set(hit_way);
    assign bp_e       = lookup_hit & ctr_q[hit_idx][1];
    assign bp_target  = bp_e ? tgt_q[hit_idx] : '0;

    assign upd_en    = br_valid && (ex_pc_q != '0);
    assign upd_hit   = |upd_match;
    assign upd_idx   = first_set(upd_match);
    assign alloc_idx = (&valid_q) ? plru_victim(lru_q) : first_set(~valid_q);

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        lru_d   = lru_q;
        if (lookup_hit && !stall[1]) lru_d = plru_touch(lru_d, hit_idx);
        // Update touch is applied last so it overrides the lookup path bits
        if (upd_en) begin
            if (upd_hit) begin
                if (br_taken) begin
                    ctr_d[upd_idx] = (ctr_q[upd_idx] == 2'd3) ? 2'd3 : ctr_q[upd_idx] + 2'd1;
                    tgt_d[upd_idx] = br_target;
                end else begin
                    ctr_d[upd_idx] = (ctr_q[upd_idx] == 2'd0) ? 2'd0 : ctr_q[upd_idx] - 2'd1;
                end
                lru_d = plru_touch(lru_d, upd_idx);
            end else if (br_taken) begin
                valid_d[alloc_idx] = 1'b1;
                tag_d[alloc_idx]   = ex_pc_q;
                tgt_d[alloc_idx]   = br_target;
                ctr_d[alloc_idx]   = CTR_INIT;
                lru_d = plru_touch(lru_d, alloc_idx);
            end
        end
    end

    always_comb begin
        ic_pc_d   = ic_pc_q;
        id_pc_d   = id_pc_q;
        id_tgt_d  = id_tgt_q;
        id_bp_e_d = id_bp_e_q;
        id_hit_d  = id_hit_q;
        ex_pc_d   = ex_pc_q;
        ex_tgt_d  = ex_tgt_q;
        ex_bp_e_d = ex_bp_e_q;
        ex_hit_d  = ex_hit_q;

        if (!stall[1])      ic_pc_d = if_pc;
        else if (!stall[2]) ic_pc_d = '0;

        if (!stall[2]) begin
            id_pc_d   = ic_pc_q;
            id_tgt_d  = bp_target;
            id_bp_e_d = bp_e;
            id_hit_d  = lookup_hit;
        end else if (!stall[3]) begin
            id_pc_d   = '0;
            id_tgt_d  = '0;
            id_bp_e_d = 1'b0;
            id_hit_d  = 1'b0;
        end

        if (!stall[3]) begin
            ex_pc_d   = id_pc_q;
            ex_tgt_d  = id_tgt_q;
            ex_bp_e_d = id_bp_e_q;
            ex_hit_d  = id_hit_q;
        end else if (!stall[4]) begin
            ex_pc_d   = '0;
            ex_tgt_d  = '0;
            ex_bp_e_d = 1'b0;
            ex_hit_d  = 1'b0;
        end

        if (flush || br_redirect) begin
            ic_pc_d   = '0;
            id_pc_d   = '0;
            id_tgt_d  = '0;
            id_bp_e_d = 1'b0;
            id_hit_d  = 1'b0;
        end
        if (flush) begin
            ex_pc_d   = '0;
            ex_tgt_d  = '0;
            ex_bp_e_d = 1'b0;
            ex_hit_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            lru_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= '0;
            end
            ic_pc_q   <= '0;
            id_pc_q   <= '0;
            id_tgt_q  <= '0;
            id_bp_e_q <= 1'b0;
            id_hit_q  <= 1'b0;
            ex_pc_q   <= '0;
            ex_tgt_q  <= '0;
            ex_bp_e_q <= 1'b0;
            ex_hit_q  <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            tgt_q     <= tgt_d;
            ctr_q     <= ctr_d;
            lru_q     <= lru_d;
            ic_pc_q   <= ic_pc_d;
            id_pc_q   <= id_pc_d;
            id_tgt_q  <= id_tgt_d;
            id_bp_e_q <= id_bp_e_d;
            id_hit_q  <= id_hit_d;
            ex_pc_q   <= ex_pc_d;
            ex_tgt_q  <= ex_tgt_d;
            ex_bp_e_q <= ex_bp_e_d;
            ex_hit_q  <= ex_hit_d;
        end
    end

    assign ex_bp_e      = ex_bp_e_q;
    assign ex_bp_target = ex_tgt_q;
    assign ex_bp_hit    = ex_hit_q;

endmodule

// File: tb/tb_bpu_btb_sat.sv
// Directed bench for bpu_btb_sat: training, counter saturation, PLRU victim choice,
// stall bubbles, flush/redirect and reset behaviour against hand-computed values.
module tb_bpu_btb_sat;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        br_redirect;
    logic [31:0] if_pc;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic        bp_e;
    logic [31:0] bp_target;
    logic        ex_bp_e;
    logic [31:0] ex_bp_target;
    logic        ex_bp_hit;

    int n_tests = 0;
    int n_fail  = 0;

    bpu_btb_sat #(.ENTRIES(8), .PC_W(32), .CTR_INIT(2'b10)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .br_redirect  (br_redirect),
        .if_pc        (if_pc),
        .br_valid     (br_valid),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .bp_e         (bp_e),
        .bp_target    (bp_target),
        .ex_bp_e      (ex_bp_e),
        .ex_bp_target (ex_bp_target),
        .ex_bp_hit    (ex_bp_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Fetch pc into IC, let it reach EX, and resolve it there
    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        if_pc = pc;
        step();
        if_pc = '0;
        step();
        step();
        br_valid  = 1'b1;
        br_taken  = tk;
        br_target = tgt;
        step();
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        $display("[TB] train pc=0x%0h taken=%0b target=0x%0h", pc, tk, tgt);
    endtask

    task automatic lookup(input logic [31:0] pc, output logic e, output logic [31:0] t);
        if_pc = pc;
        step();
        e = bp_e;
        t = bp_target;
        if_pc = '0;
        $display("[TB] fetch pc=0x%0h bp_e=%0b bp_target=0x%0h", pc, e, t);
    endtask

    task automatic fetch_chk(input string tag, input logic [31:0] pc,
                             input logic e_exp, input logic [31:0] t_exp);
        logic        e;
        logic [31:0] t;
        lookup(pc, e, t);
        chk({tag, "_bp_e"}, {63'd0, e}, {63'd0, e_exp});
        chk({tag, "_bp_target"}, {32'd0, t}, {32'd0, t_exp});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bp_e"}, {63'd0, bp_e}, 64'd0);
        chk({tag, "_bp_target"}, {32'd0, bp_target}, 64'd0);
        chk({tag, "_ex_bp_e"}, {63'd0, ex_bp_e}, 64'd0);
        chk({tag, "_ex_bp_target"}, {32'd0, ex_bp_target}, 64'd0);
        chk({tag, "_ex_bp_hit"}, {63'd0, ex_bp_hit}, 64'd0);
    endtask

    initial begin
        logic        e;
        logic [31:0] t;
        int          hits;

        rst = 1'b0; stall = '0; flush = 1'b0; br_redirect = 1'b0;
        if_pc = '0; br_valid = 1'b0; br_taken = 1'b0; br_target = '0;

        // 1: reset state, empty table never predicts, allocate then predict
        #1 rst = 1'b1;
        if_pc = 32'h100;
        step();
        step();
        chk_all_zero("t1_reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_empty_bp_e", {63'd0, bp_e}, 64'd0);
        end
        if_pc = '0;
        step(); step(); step();
        train(32'h100, 1'b1, 32'h200);
        fetch_chk("t1_refetch", 32'h100, 1'b1, 32'h200);
        step(); step();
        chk("t1_ex_bp_e", {63'd0, ex_bp_e}, 64'd1);
        chk("t1_ex_bp_target", {32'd0, ex_bp_target}, 64'h200);
        chk("t1_ex_bp_hit", {63'd0, ex_bp_hit}, 64'd1);

        // 2: not-taken training 2->1->0, saturation at 0, then back up
        train(32'h100, 1'b0, 32'h0);
        fetch_chk("t2_ctr1", 32'h100, 1'b0, 32'h0);
        step(); step();
        chk("t2_ex_hit_no_dir", {63'd0, ex_bp_hit}, 64'd1);
        chk("t2_ex_bp_e", {63'd0, ex_bp_e}, 64'd0);
        train(32'h100, 1'b0, 32'h0);
        train(32'h100, 1'b0, 32'h0);
        fetch_chk("t2_sat0", 32'h100, 1'b0, 32'h0);
        train(32'h100, 1'b1, 32'h220);
        fetch_chk("t2_up_to1", 32'h100, 1'b0, 32'h0);
        train(32'h100, 1'b1, 32'h220);
        fetch_chk("t2_up_to2", 32'h100, 1'b1, 32'h220);

        // 3: fill all 8 ways, touch way0, allocate 0x90 -> PLRU victim is way4 (0x50)
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            train(32'(k * 16), 1'b1, 32'(32'h1000 + k * 16));
        end
        fetch_chk("t3_touch10", 32'h10, 1'b1, 32'h1010);
        train(32'h90, 1'b1, 32'h1090);
        fetch_chk("t3_keep10", 32'h10, 1'b1, 32'h1010);
        fetch_chk("t3_evict50", 32'h50, 1'b0, 32'h0);
        fetch_chk("t3_new90", 32'h90, 1'b1, 32'h1090);
        hits = 0;
        for (int k = 2; k <= 8; k++) begin
            lookup(32'(k * 16), e, t);
            if (e) hits++;
        end
        chk("t3_old_hits", 64'(hits), 64'd6);

        // 4: IC held, ID bubbles into EX, then prediction arrives aligned
        do_reset();
        train(32'h100, 1'b1, 32'h200);
        if_pc = 32'h100;
        step();
        chk("t4_ic_pred", {63'd0, bp_e}, 64'd1);
        if_pc = '0;
        stall = 6'b000110;
        step();
        chk("t4_bubble1", {63'd0, ex_bp_e}, 64'd0);
        chk("t4_ic_hold", {32'd0, bp_target}, 64'h200);
        step();
        chk("t4_bubble2", {63'd0, ex_bp_e}, 64'd0);
        stall = '0;
        step();
        chk("t4_release_id", {63'd0, ex_bp_e}, 64'd0);
        step();
        chk("t4_ex_bp_e", {63'd0, ex_bp_e}, 64'd1);
        chk("t4_ex_bp_target", {32'd0, ex_bp_target}, 64'h200);
        chk("t4_ex_bp_hit", {63'd0, ex_bp_hit}, 64'd1);
        // Resolve not-taken here: only trains 0x100 if EX really holds it now
        br_valid = 1'b1;
        br_taken = 1'b0;
        step();
        br_valid = 1'b0;
        fetch_chk("t4_aligned", 32'h100, 1'b0, 32'h0);

        // 5: flush empties IC/ID/EX; redirect empties IC/ID only
        train(32'h100, 1'b1, 32'h200);
        if_pc = 32'h100;
        step(); step(); step();
        chk("t5_pre_flush", {63'd0, ex_bp_e}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_flush_ex_bp_e", {63'd0, ex_bp_e}, 64'd0);
        chk("t5_flush_ex_hit", {63'd0, ex_bp_hit}, 64'd0);
        chk("t5_flush_bp_e", {63'd0, bp_e}, 64'd0);
        step(); step(); step();
        chk("t5_refill", {63'd0, ex_bp_e}, 64'd1);
        br_redirect = 1'b1;
        step();
        br_redirect = 1'b0;
        if_pc = '0;
        chk("t5_redir_ex_kept", {63'd0, ex_bp_e}, 64'd1);
        chk("t5_redir_ic", {63'd0, bp_e}, 64'd0);
        step();
        chk("t5_redir_id", {63'd0, ex_bp_e}, 64'd0);

        // 6: same-cycle allocate and lookup of 0x300, then async reset mid-cycle
        do_reset();
        if_pc = 32'h300;
        step();
        if_pc = '0;
        step();
        if_pc = 32'h300;
        step();
        if_pc = '0;
        br_valid  = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h400;
        #1;
        chk("t6_same_cycle", {63'd0, bp_e}, 64'd0);
        step();
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        fetch_chk("t6_later", 32'h300, 1'b1, 32'h400);
        if_pc = 32'h300;
        step(); step(); step();
        chk("t6_pre_rst", {63'd0, ex_bp_e}, 64'd1);
        #3 rst = 1'b1;
        #1;
        chk_all_zero("t6_mid_rst");
        step();
        rst = 1'b0;
        if_pc = '0;
        fetch_chk("t6_after_rst", 32'h300, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
